flag_branch_ctrl: RTL and testbench

Consumer and write-back controller for the 3-bit condition flag register (Z, N, C) in the five-stage pipeline. Resolves conditional jumps against forwarded flag values, issues the clear-on-taken flag write back to the flag register, and keeps a shadow stack of flags for interrupt save and return-from-interrupt restore. Sits in the decode/execute boundary: flag register read port in, flag register write port out.

---
 rtl/flag_branch_ctrl.sv | 142 ++++++++++++++
 tb/tb_flag_branch_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_ctrl.sv
// Condition-flag consumer: resolves conditional jumps against forwarded flags, issues the
// clear-on-taken write back, and keeps a LIFO shadow stack for interrupt save/restore.
module flag_branch_ctrl #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] flags_in,
   input  logic             ex_flag_we,
   input  logic [WIDTH-1:0] ex_flags,
   input  logic             br_valid,
   input  logic [1:0]       br_cond,
   input  logic             int_save,
   input  logic             rti_restore,
   output logic             taken,
   output logic             flag_we,
   output logic [WIDTH-1:0] flag_wdata,
   output logic             stack_empty,
   output logic             stack_full,
   output logic             err
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      CondZ   = 2'b00,
      CondN   = 2'b01,
      CondC   = 2'b10,
      CondJmp = 2'b11
   } cond_e;

   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             taken_q, taken_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] eff;
   logic [WIDTH-1:0] clr_mask;
   logic [WIDTH-1:0] top;
   logic             cond_true;
   logic             br_hit;
   logic             clr_req;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;
   logic             save_err;
   logic             rti_err;

   // Our own write is not visible on flags_in until the register commits, so forward it.
   always_comb begin
      eff = flags_in;
      if (ex_flag_we) begin
         eff = ex_flags;
      end else if (we_q) begin
         eff = wdata_q;
      end
   end

   always_comb begin
      cond_true = 1'b0;
      unique case (cond_e'(br_cond))
         CondZ:   cond_true = eff[0];
         CondN:   cond_true = eff[1];
         CondC:   cond_true = eff[2];
         CondJmp: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   assign br_hit   = br_valid & cond_true;
   assign clr_req  = br_hit & (cond_e'(br_cond) != CondJmp);
   assign clr_mask = ~(WIDTH'(1) << br_cond);

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));

   // Save wins over a coincident restore; the restore is silently ignored.
   assign do_push  = int_save & ~full;
   assign save_err = int_save & full;
   assign do_pop   = rti_restore & ~int_save & ~empty;
   assign rti_err  = rti_restore & ~int_save & empty;

   assign top      = stack_q[AW'(count_q - CW'(1))];

   always_comb begin
      taken_d = br_hit;
      err_d   = save_err | rti_err;
      we_d    = 1'b0;
      wdata_d = '0;
      count_d = count_q;

      if (do_push) begin
         count_d = count_q + CW'(1);
      end else if (do_pop) begin
         count_d = count_q - CW'(1);
      end

      // A restore write displaces the branch clear; taken is still reported.
      if (do_pop) begin
         we_d    = 1'b1;
         wdata_d = top;
      end else if (clr_req) begin
         we_d    = 1'b1;
         wdata_d = eff & clr_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         taken_q <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         taken_q <= taken_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push) begin
         stack_q[AW'(count_q)] <= eff;
      end
   end

   assign taken       = taken_q;
   assign flag_we     = we_q;
   assign flag_wdata  = wdata_q;
   assign err         = err_q;
   assign stack_empty = empty;
   assign stack_full  = full;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Bench for flag_branch_ctrl: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the flag/stack behaviour.
module tb_flag_branch_ctrl;

   localparam int unsigned WIDTH = 3;
   localparam int unsigned DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] flags_in;
   logic             ex_flag_we;
   logic [WIDTH-1:0] ex_flags;
   logic             br_valid;
   logic [1:0]       br_cond;
   logic             int_save;
   logic             rti_restore;
   logic             taken;
   logic             flag_we;
   logic [WIDTH-1:0] flag_wdata;
   logic             stack_empty;
   logic             stack_full;
   logic             err;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic             m_taken, m_we, m_err;
   logic [WIDTH-1:0] m_wdata;
   logic [WIDTH-1:0] m_stack[$];
   bit               reg_mode = 1'b0;

   flag_branch_ctrl #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flags_in   (flags_in),
      .ex_flag_we (ex_flag_we),
      .ex_flags   (ex_flags),
      .br_valid   (br_valid),
      .br_cond    (br_cond),
      .int_save   (int_save),
      .rti_restore(rti_restore),
      .taken      (taken),
      .flag_we    (flag_we),
      .flag_wdata (flag_wdata),
      .stack_empty(stack_empty),
      .stack_full (stack_full),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle();
      reset       = 1'b0;
      ex_flag_we  = 1'b0;
      ex_flags    = '0;
      br_valid    = 1'b0;
      br_cond     = 2'b00;
      int_save    = 1'b0;
      rti_restore = 1'b0;
   endtask

   // Predict from the spec rules, advance one clock, compare every output.
   task automatic cycle();
      logic [WIDTH-1:0] eff;
      logic             n_taken, n_we, n_err, hit;
      logic [WIDTH-1:0] n_wdata;
      int               c;
      c       = int'(br_cond);
      eff     = ex_flag_we ? ex_flags : (m_we ? m_wdata : flags_in);
      hit     = (c == 3) ? 1'b1 : eff[c];
      n_taken = br_valid && hit;
      n_we    = 1'b0;
      n_wdata = '0;
      n_err   = 1'b0;
      if (int_save) begin
         if (m_stack.size() < DEPTH) m_stack.push_back(eff);
         else n_err = 1'b1;
      end else if (rti_restore) begin
         if (m_stack.size() > 0) begin
            n_we    = 1'b1;
            n_wdata = m_stack.pop_back();
         end else begin
            n_err = 1'b1;
         end
      end
      if (!n_we && n_taken && c != 3) begin
         n_we    = 1'b1;
         n_wdata = eff & ~WIDTH'(1 << c);
      end
      if (reset) begin
         n_taken = 1'b0;
         n_we    = 1'b0;
         n_wdata = '0;
         n_err   = 1'b0;
         m_stack.delete();
      end
      m_taken = n_taken;
      m_we    = n_we;
      m_wdata = n_wdata;
      m_err   = n_err;

      @(posedge clk);
      #1;
      chk("taken", 32'(taken), 32'(m_taken));
      chk("flag_we", 32'(flag_we), 32'(m_we));
      chk("flag_wdata", 32'(flag_wdata), 32'(m_wdata));
      chk("err", 32'(err), 32'(m_err));
      chk("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
      chk("stack_full", 32'(stack_full), 32'(m_stack.size() == DEPTH));
      if (reg_mode) begin
         @(negedge clk);
         if (m_we) flags_in = m_wdata;
      end
   endtask

   initial begin
      m_taken  = 1'b0;
      m_we     = 1'b0;
      m_err    = 1'b0;
      m_wdata  = '0;
      flags_in = '0;
      idle();

      // Reset state
      reset = 1'b1;
      cycle();
      cycle();
      idle();

      // JZ on Z=1: taken, clear Z; next cycle all low
      flags_in = 3'b001; br_valid = 1'b1; br_cond = 2'b00;
      cycle();
      chk("jz_wdata_const", 32'(flag_wdata), 32'h0);
      idle();
      cycle();
      chk("jz_after_taken", 32'(taken), 32'h0);
      cycle();

      // JN using execute-stage forwarded flags, then without forwarding
      flags_in = 3'b000; ex_flag_we = 1'b1; ex_flags = 3'b010;
      br_valid = 1'b1; br_cond = 2'b01;
      cycle();
      chk("jn_fwd_taken", 32'(taken), 32'h1);
      idle();
      cycle();
      flags_in = 3'b000; br_valid = 1'b1; br_cond = 2'b01;
      cycle();
      chk("jn_nofwd_taken", 32'(taken), 32'h0);
      idle();

      // Back-to-back JZ then JC with flags_in unchanged
      flags_in = 3'b101; br_valid = 1'b1; br_cond = 2'b00;
      cycle();
      chk("b2b_first_wdata", 32'(flag_wdata), 32'h4);
      br_cond = 2'b10;
      cycle();
      chk("b2b_second_wdata", 32'(flag_wdata), 32'h0);
      idle();
      cycle();

      // JMP: taken, no write
      br_valid = 1'b1; br_cond = 2'b11;
      cycle();
      idle();

      // Push two, pop two, underflow
      flags_in = 3'b011; int_save = 1'b1;
      cycle();
      flags_in = 3'b110;
      cycle();
      idle();
      rti_restore = 1'b1;
      cycle();
      chk("pop1_wdata", 32'(flag_wdata), 32'h6);
      cycle();
      chk("pop2_wdata", 32'(flag_wdata), 32'h3);
      cycle();
      chk("underflow_err", 32'(err), 32'h1);
      idle();
      cycle();

      // Overflow with DEPTH+1 saves, then drain
      int_save = 1'b1;
      for (int i = 1; i <= DEPTH + 1; i++) begin
         flags_in = WIDTH'(i);
         cycle();
      end
      idle();
      rti_restore = 1'b1;
      for (int i = DEPTH; i >= 1; i--) begin
         cycle();
      end
      idle();
      cycle();

      // Simultaneous save/restore at count=1, then reset clears stack
      flags_in = 3'b010; int_save = 1'b1;
      cycle();
      flags_in = 3'b001; rti_restore = 1'b1;
      cycle();
      idle();
      reset = 1'b1;
      cycle();
      idle();

      // Coincident restore and branch clear: restore value wins
      flags_in = 3'b111; int_save = 1'b1;
      cycle();
      idle();
      flags_in = 3'b001; rti_restore = 1'b1; br_valid = 1'b1; br_cond = 2'b00;
      cycle();
      idle();
      cycle();

      // Random traffic with a modelled flag register committing writes
      reg_mode = 1'b1;
      flags_in = WIDTH'($urandom);
      for (int n = 0; n < 400; n++) begin
         reset       = ($urandom_range(0, 49) == 0);
         ex_flag_we  = ($urandom_range(0, 2) == 0);
         ex_flags    = WIDTH'($urandom);
         br_valid    = ($urandom_range(0, 1) == 0);
         br_cond     = 2'($urandom);
         int_save    = ($urandom_range(0, 4) == 0);
         rti_restore = ($urandom_range(0, 4) == 0);
         cycle();
      end
      idle();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
